// File: rtl/cpu_mem_stage.sv
// ============================================================================
// cpu_mem_stage
// ----------------------------------------------------------------------------
// Memory stage of a 5-stage pipeline. It holds the EX result in the M
// register and issues loads/stores to a data memory that can take a variable
// number of cycles, signalled by mem_ready. While a request is outstanding
// the stage asserts a combinational stall that freezes the earlier stages.
// A zero-wait memory (mem_ready already high) completes in the issue cycle
// and costs no bubble. The MEM/WB register captures the result every edge
// and inserts a bubble (wb_regWrite=0) whenever the stage is stalled.
//
// Optional feature: define MEM_TIMEOUT_EN to enable a 4-bit watchdog on the
// WAIT state. After 15 WAIT cycles without mem_ready the request is dropped,
// the stall is released and the sticky mem_err flag is set until rst.
// Without the macro the stage waits forever and mem_err is tied to 0.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   ex_valid           EX slot holds a real instruction
//   ex_aluOut          ALU result: load/store address or writeback value
//   ex_storeData       forwarded rt value for stores
//   ex_regW            destination register
//   ex_memRead         instruction is a load
//   ex_memWrite        instruction is a store
//   ex_regWrite        instruction writes the register file
//   mem_addr           data memory address
//   mem_wdata          data memory write data
//   mem_en             data memory request
//   mem_wr             1 = write, 0 = read (qualified by mem_en)
//   mem_rdata          read data, valid with mem_ready
//   mem_ready          memory completes the current request this cycle
//   stall              freeze PC/IF/ID/EX and hold EX outputs
//   MEM_faddress       M-register ALU result (EX-to-EX forward source)
//   MEM_regW           M-register destination
//   MEM_regWrite       M-register valid & regWrite & ~memWrite
//   wb_data            MEM/WB data (WB-to-EX forward source)
//   wb_regW            MEM/WB destination
//   wb_regWrite        MEM/WB commit strobe
//   mem_err            sticky timeout error
// ============================================================================
module cpu_mem_stage (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid,
    input  logic [15:0] ex_aluOut,
    input  logic [15:0] ex_storeData,
    input  logic [3:0]  ex_regW,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic        ex_regWrite,

    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,

    output logic        stall,

    output logic [15:0] MEM_faddress,
    output logic [3:0]  MEM_regW,
    output logic        MEM_regWrite,

    output logic [15:0] wb_data,
    output logic [3:0]  wb_regW,
    output logic        wb_regWrite,

    output logic        mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state_q;

    // ------------------------------------------------------------------
    // M register
    // ------------------------------------------------------------------
    logic        m_valid_q;
    logic [15:0] m_alu_q;
    logic [15:0] m_store_q;
    logic [3:0]  m_regw_q;
    logic        m_memread_q;
    logic        m_memwrite_q;
    logic        m_regwrite_q;

    logic        mem_op;       // M slot holds a valid load or store
    logic        timeout_hit;  // watchdog expired this cycle (0 when disabled)
    logic        complete;     // M slot retires into MEM/WB this edge

    // ------------------------------------------------------------------
    // Memory request: driven straight from the M register. Because the M
    // register is frozen while stalled, address/data/direction stay stable
    // for the whole WAIT period without any extra holding registers.
    // ------------------------------------------------------------------
    assign mem_op    = m_valid_q & (m_memread_q | m_memwrite_q);
    assign mem_en    = mem_op;
    assign mem_addr  = m_alu_q;
    assign mem_wdata = m_store_q;
    assign mem_wr    = m_memwrite_q;

    // Combinational so a ready memory lets the pipeline advance in the same
    // cycle; the watchdog forces the stall low on the cycle it fires.
    assign stall = mem_en & ~mem_ready & ~timeout_hit;

    // An aborted request releases the stall but must not retire.
    assign complete = ~stall & ~timeout_hit;

    // Forwarding views of the M register
    assign MEM_faddress = m_alu_q;
    assign MEM_regW     = m_regw_q;
    assign MEM_regWrite = m_valid_q & m_regwrite_q & ~m_memwrite_q;

    // ------------------------------------------------------------------
    // Optional WAIT-state watchdog
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    logic [3:0] tmo_cnt_q;
    logic       err_q;

    // Fires on the 16th WAIT cycle (counter value 15) if memory is still busy;
    // a late mem_ready on that same cycle still completes normally.
    assign timeout_hit = (state_q == S_WAIT) & (tmo_cnt_q == 4'd15) & ~mem_ready;
    assign mem_err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            // Held at zero in IDLE so the count starts fresh on WAIT entry
            if (state_q == S_IDLE) begin
                tmo_cnt_q <= 4'd0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 4'd1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request FSM. IDLE only moves to WAIT when the memory did not answer
    // in the issue cycle; WAIT leaves on mem_ready or on watchdog abort.
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers sample the pre-edge values of each other; blocking here would
    // make results depend on statement order and mismatch synthesis.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mem_op && !mem_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ready || timeout_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // M register: advances whenever the stage is not stalled
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            m_alu_q      <= 16'h0000;
            m_store_q    <= 16'h0000;
            m_regw_q     <= 4'd0;
            m_memread_q  <= 1'b0;
            m_memwrite_q <= 1'b0;
            m_regwrite_q <= 1'b0;
        end else if (!stall) begin
            m_valid_q    <= ex_valid;
            m_alu_q      <= ex_aluOut;
            m_store_q    <= ex_storeData;
            m_regw_q     <= ex_regW;
            m_memread_q  <= ex_memRead;
            m_memwrite_q <= ex_memWrite;
            m_regwrite_q <= ex_regWrite;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register: updates every edge. A stalled or aborted slot
    // becomes a bubble while data/destination keep their last value so
    // the WB forwarding path stays quiet.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data     <= 16'h0000;
            wb_regW     <= 4'd0;
            wb_regWrite <= 1'b0;
        end else if (complete) begin
            wb_data     <= m_memread_q ? mem_rdata : m_alu_q;
            wb_regW     <= m_regw_q;
            // Stores never commit, even when the decoder set regWrite
            wb_regWrite <= m_valid_q & m_regwrite_q & ~m_memwrite_q;
        end else begin
            wb_regWrite <= 1'b0;
        end
    end

endmodule

// File: doc/cpu_mem_stage.md
CPU_MEM_STAGE -- requirements
Module: cpu_mem_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are listed below with width and meaning, one per line.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  EX result valid this cycle.
- ex_aluOut  in  16  ALU result from EX; load/store address or writeback value.
- ex_storeData  in  16  forwarded rt data for stores.
- ex_regW  in  4  destination register from EX.
- ex_memRead  in  1  load.
- ex_memWrite  in  1  store.
- ex_regWrite  in  1  op writes register file.
- mem_addr  out  16  data memory address.
- mem_wdata  out  16  data memory write data.
- mem_en  out  1  memory request.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_en.
- mem_rdata  in  16  read data, valid with mem_ready.
- mem_ready  in  1  memory completes current request this cycle.
- stall  out  1  freeze PC/IF/ID/EX and hold EX outputs.
- MEM_faddress  out  16  M-register ALU result, EX-to-EX forward source.
- MEM_regW  out  4  M-register destination.
- MEM_regWrite  out  1  M-register valid & regWrite & ~memWrite.
- wb_data  out  16  MEM/WB data, WB-to-EX forward source.
- wb_regW  out  4  MEM/WB destination.
- wb_regWrite  out  1  MEM/WB commit strobe.
- mem_err  out  1  sticky timeout error.

Function
REQ-002 SHALL hold an M register {valid, aluOut, storeData, regW, memRead, memWrite, regWrite} loaded from ex_* each edge when stall=0; held when stall=1.
REQ-003 SHALL run a FSM with states IDLE, WAIT.
- mem_en = M.valid & (M.memRead | M.memWrite), combinational, in IDLE and WAIT.
- mem_addr = M.aluOut, mem_wdata = M.storeData, mem_wr = M.memWrite.
REQ-004 IDLE with mem op and mem_ready=1: op completes in the same cycle, stall=0, stay IDLE (zero-wait memory costs no bubble).
REQ-005 IDLE with mem op and mem_ready=0: stall=1, go to WAIT.
REQ-006 WAIT: stall=1 and mem_addr/mem_wdata/mem_wr held stable until mem_ready=1; that cycle stall=0, op completes, go to IDLE.
REQ-007 stall SHALL be purely combinational: mem_en & ~mem_ready (plus timeout override, REQ-015).
REQ-008 MEM/WB register SHALL update every edge.
- stall=0: wb_data <= M.memRead ? mem_rdata : M.aluOut; wb_regW <= M.regW; wb_regWrite <= M.valid & M.regWrite & ~M.memWrite.
- stall=1: wb_regWrite <= 0 (bubble); wb_data and wb_regW hold.
REQ-009 Non-memory ops and invalid slots SHALL pass through in one cycle with mem_en=0.
REQ-010 mem_ready while mem_en=0 SHALL be ignored.
REQ-011 A store SHALL never assert wb_regWrite, even if ex_regWrite=1.
REQ-012 Back-to-back memory ops SHALL each issue a separate request; the second issues the cycle after the first completes.

Reset
REQ-013 On rst=1 at an edge: M.valid=0, all M fields 0, state IDLE, wb_data=0, wb_regW=0, wb_regWrite=0, mem_err=0; mem_en and stall therefore 0 the following cycle.
REQ-014 Reset during WAIT SHALL abandon the request; no writeback and no stall after the reset edge.

Configuration
REQ-015 With macro MEM_TIMEOUT_EN defined:
- 4-bit counter clears on entry to WAIT and increments each WAIT cycle.
- When the counter reaches 15 with mem_ready=0: stall=0 that cycle, op aborted (wb_regWrite <= 0), mem_err <= 1 sticky until rst, next state IDLE.
REQ-016 Without MEM_TIMEOUT_EN: WAIT persists indefinitely, no counter is present, and mem_err is tied 0.

Verification
REQ-017 ALU op ex_aluOut=0x1234, regW=3, regWrite=1 -> next cycle wb_data=0x1234, wb_regW=3, wb_regWrite=1; mem_en stays 0.
REQ-018 Load addr 0x0040, mem_ready held 1, mem_rdata=0xBEEF -> stall never asserts; wb_data=0xBEEF one cycle later.
REQ-019 Store addr 0x0010, data 0xA5A5, mem_ready after 3 cycles -> stall=1 for 3 cycles, mem_addr/mem_wdata stable, mem_wr=1, wb_regWrite stays 0.
REQ-020 Load then dependent ALU op, memory 2-wait -> load writeback once, bubble (wb_regWrite=0) during stall, ALU op follows, no duplicate commits.
REQ-021 rst pulsed in WAIT cycle 2 -> mem_en=0, stall=0 next cycle, all outputs at reset values.
REQ-022 MEM_TIMEOUT_EN, load with mem_ready never asserted -> stall drops after WAIT cycle 15, mem_err=1, no writeback; mem_err persists until rst.
